var_state_base: RTL and testbench
=================================

# var_state_base

Variable-state store for one bin: the producing end of the clause interface.
- Holds value, implied flag and decision level for NUM_VARS_A_BIN variables.
- Drives var_value_frombase_o into every clause of the bin and collects the clauses' var_value_tobase vectors.
- Runs decide → propagate → settle/conflict, and applies backtrack on command, including the one-cycle apply_backtrack pulse.
- Sits between the bin controller (decisions, backtrack) and the clause array.

## Interface
- NUM_VARS_A_BIN, 8, variables per bin
- NUM_CLAUSES, 8, clauses attached to this base
- LVL_W, 5, decision-level width
- IDX_W, 3, variable-index width; equals $clog2(NUM_VARS_A_BIN)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start_i  in  1  decision request; accepted only in IDLE
- decision_var_i  in  IDX_W  decided variable index
- decision_value_i  in  1  decided polarity; 1 = true
- decision_level_i  in  LVL_W  level of the decision
- bkt_i  in  1  backtrack request; accepted only in IDLE
- bkt_level_i  in  LVL_W  keep variables with level ≤ this
- var_value_tobase_i  in  NUM_CLAUSES*NUM_VARS_A_BIN*3  concatenated clause outputs; clause c occupies slice [c*NUM_VARS_A_BIN*3 +: NUM_VARS_A_BIN*3]
- var_value_frombase_o  out  NUM_VARS_A_BIN*3  per-variable state to clauses
- apply_backtrack_o  out  1  one-cycle pulse to clauses
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse; propagation settled without conflict
- conflict_o  out  1  one-cycle pulse; conflict detected
- conflict_var_o  out  IDX_W  lowest index in conflict; valid while conflict_o = 1

## Operation
- frombase field per variable, 3 bits: {val[1:0], implied}.
  - val: 00 free, 01 false, 10 true; 11 is never driven.
  - implied = 1 only for assignments made by propagation.
- tobase field per variable, 3 bits: {imp_valid, imp_value, cflt}.
  - cflt = 1 marks a clause that is fully false.
- FSM states: IDLE, PROPAGATE, BACKTRACK.
- IDLE, start_i = 1:
  - Writes decision_var_i ← val per decision_value_i, implied = 0, level = decision_level_i.
  - Latches cur_level ← decision_level_i.
  - Goes to PROPAGATE.
  - A decision on an already-assigned variable overwrites it.
- IDLE, bkt_i = 1:
  - Goes to BACKTRACK.
  - start_i and bkt_i both high: bkt_i wins and start_i is ignored.
- PROPAGATE, each cycle, per variable, OR-reduced over all clauses:
  - req_t = any (imp_valid and imp_value).
  - req_f = any (imp_valid and not imp_value).
  - Conflict when any of the following holds:
    - any cflt bit is set on any field;
    - req_t and req_f are both set;
    - the request opposes the assigned value.
  - On conflict: pulse conflict_o, write nothing, return to IDLE.
  - Otherwise every free variable with a request is assigned: implied = 1, level = cur_level.
  - A request that matches the existing value is ignored.
  - No new assignment this cycle: pulse done_o, return to IDLE.
- BACKTRACK, single cycle:
  - Every variable with level > bkt_level_i becomes free (val 00, implied 0, level 0).
  - apply_backtrack_o = 1 for that cycle only.
  - Returns to IDLE.
- Stored per-variable state is held across IDLE; it changes only in the transitions above.

## Timing
- Reset (rst = 0 at a clk edge):
  - All variables free, state IDLE.
  - All outputs 0, including var_value_frombase_o = 0.
  - Reset mid-PROPAGATE or mid-BACKTRACK aborts; no done_o or conflict_o is emitted.
- var_value_frombase_o is a registered function of the stored state.
- Clauses are combinational: tobase reflects frombase in the same cycle.
- The decision is visible on frombase the cycle after the start_i edge.
- The first PROPAGATE sample happens at the next edge.
- Each implication wave costs 1 cycle.
- Propagation terminates within NUM_VARS_A_BIN + 1 PROPAGATE cycles, because every non-final cycle assigns at least one variable.
- busy_o is high from the cycle after acceptance through the cycle in which done_o, conflict_o or apply_backtrack_o is high.
- Requests seen while busy_o = 1 are dropped.

## Structure
- Package sat_base_pkg holds:
  - VAL_FREE, VAL_FALSE, VAL_TRUE constants;
  - field widths;
  - the FSM state enum.
- Sub-module var_imp_merge, one instance per variable:
  - Input: that variable's tobase fields from all clauses.
  - Outputs: req_t, req_f, cflt.
- The top level holds state registers, the FSM and conflict priority encoding.

## Test plan
Bench settings: NUM_VARS_A_BIN = 8, NUM_CLAUSES = 2; clause outputs are driven directly by the bench.
- Reset, then start_i with var 1, value 0, level 1, tobase = 0 → next cycle field 1 = 3'b010; done_o pulses after one PROPAGATE cycle; busy_o drops.
- Clause 0 requests var 3 true in the first PROPAGATE cycle, then 0 → field 3 = 3'b101 and var 3 stores level 1; done_o pulses on the second PROPAGATE cycle.
- Clause 0 requests var 5 true while clause 1 requests var 5 false → conflict_o pulses with conflict_var_o = 5; field 5 stays 3'b000.
- Any cflt bit set in clause 1 during PROPAGATE → conflict_o pulses the same cycle; no state is written.
- Vars 1, 3 at level 1 and var 5 at level 2, then bkt_i with bkt_level_i = 1 → var 5 freed; vars 1 and 3 keep their fields; apply_backtrack_o is high for exactly one cycle.
- rst driven low during PROPAGATE → all fields 0 next cycle, no done_o or conflict_o; start_i and bkt_i asserted together in IDLE → only the backtrack occurs.

Source files
------------

// File: rtl/sat_base_pkg.sv
// Shared encodings for the per-bin variable store and its clause interface.
// Field layouts: frombase {val[1:0], implied}, tobase {imp_valid, imp_value, cflt}.
package sat_base_pkg;
   localparam int VAL_W   = 2;
   localparam int FIELD_W = 3;

   localparam logic [VAL_W-1:0] VAL_FREE  = 2'b00;
   localparam logic [VAL_W-1:0] VAL_FALSE = 2'b01;
   localparam logic [VAL_W-1:0] VAL_TRUE  = 2'b10;

   localparam int TB_IMP_VALID = 2;
   localparam int TB_IMP_VALUE = 1;
   localparam int TB_CFLT      = 0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PROPAGATE = 2'd1,
      ST_BACKTRACK = 2'd2
   } state_t;
endpackage

// File: rtl/var_imp_merge.sv
// OR-reduces one variable's tobase fields over all clauses into req_t/req_f/cflt.
// Purely combinational, zero latency, no flow control.
module var_imp_merge
   import sat_base_pkg::*;
#(
   parameter int NUM_CLAUSES = 8
) (
   input  logic [NUM_CLAUSES*FIELD_W-1:0] fields,
   output logic                           req_t,
   output logic                           req_f,
   output logic                           cflt
);

   always_comb begin
      req_t = 1'b0;
      req_f = 1'b0;
      cflt  = 1'b0;
      for (int c = 0; c < NUM_CLAUSES; c++) begin
         req_t = req_t | (fields[c*FIELD_W+TB_IMP_VALID] &  fields[c*FIELD_W+TB_IMP_VALUE]);
         req_f = req_f | (fields[c*FIELD_W+TB_IMP_VALID] & ~fields[c*FIELD_W+TB_IMP_VALUE]);
         cflt  = cflt  |  fields[c*FIELD_W+TB_CFLT];
      end
   end

endmodule

// File: rtl/var_state_base.sv
// Per-bin variable store: decide, one-cycle-per-wave propagation, backtrack.
// Outputs pulse combinationally in the final busy cycle; requests while busy are dropped.
module var_state_base
   import sat_base_pkg::*;
#(
   parameter int NUM_VARS_A_BIN = 8,
   parameter int NUM_CLAUSES    = 8,
   parameter int LVL_W          = 5,
   parameter int IDX_W          = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start_i,
   input  logic [IDX_W-1:0]                          decision_var_i,
   input  logic                                      decision_value_i,
   input  logic [LVL_W-1:0]                          decision_level_i,
   input  logic                                      bkt_i,
   input  logic [LVL_W-1:0]                          bkt_level_i,
   input  logic [NUM_CLAUSES*NUM_VARS_A_BIN*FIELD_W-1:0] var_value_tobase_i,
   output logic [NUM_VARS_A_BIN*FIELD_W-1:0]         var_value_frombase_o,
   output logic                                      apply_backtrack_o,
   output logic                                      busy_o,
   output logic                                      done_o,
   output logic                                      conflict_o,
   output logic [IDX_W-1:0]                          conflict_var_o
);

   state_t                    state_q;
   logic [VAL_W-1:0]          val_q [NUM_VARS_A_BIN];
   logic [NUM_VARS_A_BIN-1:0] imp_q;
   logic [LVL_W-1:0]          lvl_q [NUM_VARS_A_BIN];
   logic [LVL_W-1:0]          cur_level_q;
   logic [LVL_W-1:0]          bkt_level_q;

   logic [NUM_VARS_A_BIN-1:0] req_t;
   logic [NUM_VARS_A_BIN-1:0] req_f;
   logic [NUM_VARS_A_BIN-1:0] clause_cflt;
   logic [NUM_VARS_A_BIN-1:0] var_cflt;
   logic [NUM_VARS_A_BIN-1:0] new_asg;
   logic [IDX_W-1:0]          cflt_idx;
   logic                      any_cflt;
   logic                      in_prop;

   for (genvar v = 0; v < NUM_VARS_A_BIN; v++) begin : g_var
      logic [NUM_CLAUSES*FIELD_W-1:0] fields;

      for (genvar c = 0; c < NUM_CLAUSES; c++) begin : g_clause
         assign fields[c*FIELD_W +: FIELD_W] =
            var_value_tobase_i[(c*NUM_VARS_A_BIN+v)*FIELD_W +: FIELD_W];
      end

      var_imp_merge #(.NUM_CLAUSES(NUM_CLAUSES)) u_merge (
         .fields (fields),
         .req_t  (req_t[v]),
         .req_f  (req_f[v]),
         .cflt   (clause_cflt[v])
      );

      assign var_cflt[v] = clause_cflt[v]
                         | (req_t[v] & req_f[v])
                         | (req_t[v] & (val_q[v] == VAL_FALSE))
                         | (req_f[v] & (val_q[v] == VAL_TRUE));
      assign new_asg[v]  = (val_q[v] == VAL_FREE) & (req_t[v] | req_f[v]);

      assign var_value_frombase_o[v*FIELD_W +: FIELD_W] = {val_q[v], imp_q[v]};
   end

   // Descending scan so the lowest conflicting index is the one left standing.
   always_comb begin
      cflt_idx = '0;
      for (int v = NUM_VARS_A_BIN - 1; v >= 0; v--) begin
         if (var_cflt[v]) cflt_idx = IDX_W'(v);
      end
   end

   assign any_cflt          = |var_cflt;
   assign in_prop           = (state_q == ST_PROPAGATE);
   assign busy_o            = (state_q != ST_IDLE);
   assign apply_backtrack_o = (state_q == ST_BACKTRACK);
   assign conflict_o        = in_prop & any_cflt;
   assign done_o            = in_prop & ~any_cflt & ~(|new_asg);
   assign conflict_var_o    = conflict_o ? cflt_idx : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         imp_q       <= '0;
         cur_level_q <= '0;
         bkt_level_q <= '0;
         for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
            val_q[v] <= VAL_FREE;
            lvl_q[v] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bkt_i) begin
                  bkt_level_q <= bkt_level_i;
                  state_q     <= ST_BACKTRACK;
               end else if (start_i) begin
                  val_q[decision_var_i] <= decision_value_i ? VAL_TRUE : VAL_FALSE;
                  imp_q[decision_var_i] <= 1'b0;
                  lvl_q[decision_var_i] <= decision_level_i;
                  cur_level_q           <= decision_level_i;
                  state_q               <= ST_PROPAGATE;
               end
            end
            ST_PROPAGATE: begin
               if (any_cflt || !(|new_asg)) begin
                  state_q <= ST_IDLE;
               end else begin
                  for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
                     if (new_asg[v]) begin
                        val_q[v] <= req_t[v] ? VAL_TRUE : VAL_FALSE;
                        imp_q[v] <= 1'b1;
                        lvl_q[v] <= cur_level_q;
                     end
                  end
               end
            end
            ST_BACKTRACK: begin
               for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
                  if (lvl_q[v] > bkt_level_q) begin
                     val_q[v] <= VAL_FREE;
                     imp_q[v] <= 1'b0;
                     lvl_q[v] <= '0;
                  end
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_var_state_base.sv
// Bench for var_state_base: the bench plays the clause array, a scoreboard queue
// carries expected outcomes from the driver to an independent negedge monitor.
module tb_var_state_base;
   localparam int NV = 8;
   localparam int NC = 2;
   localparam int FW = 3;
   localparam int TW = NC*NV*FW;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [2:0]      decision_var_i;
   logic            decision_value_i;
   logic [4:0]      decision_level_i;
   logic            bkt_i;
   logic [4:0]      bkt_level_i;
   logic [TW-1:0]   var_value_tobase_i;
   logic [NV*FW-1:0] var_value_frombase_o;
   logic            apply_backtrack_o;
   logic            busy_o;
   logic            done_o;
   logic            conflict_o;
   logic [2:0]      conflict_var_o;

   var_state_base #(.NUM_VARS_A_BIN(NV), .NUM_CLAUSES(NC), .LVL_W(5), .IDX_W(3)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start_i              (start_i),
      .decision_var_i       (decision_var_i),
      .decision_value_i     (decision_value_i),
      .decision_level_i     (decision_level_i),
      .bkt_i                (bkt_i),
      .bkt_level_i          (bkt_level_i),
      .var_value_tobase_i   (var_value_tobase_i),
      .var_value_frombase_o (var_value_frombase_o),
      .apply_backtrack_o    (apply_backtrack_o),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .conflict_o           (conflict_o),
      .conflict_var_o       (conflict_var_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              kind;   // 0 done, 1 conflict, 2 backtrack
      int              cvar;
      logic [NV*FW-1:0] fb;
   } exp_t;

   exp_t           sbq[$];
   int             checks = 0;
   int             errors = 0;

   // Reference model: value code 0 free, 1 false, 2 true.
   logic [1:0]     mval [NV];
   logic [NV-1:0]  mimp;
   int             mlvl [NV];
   int             mcur;
   logic [TW-1:0]  plan[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [NV*FW-1:0] snap();
      logic [NV*FW-1:0] s;
      for (int v = 0; v < NV; v++) s[v*FW +: FW] = {mval[v], mimp[v]};
      return s;
   endfunction

   function automatic logic [TW-1:0] fld(input int c, input int v, input logic [2:0] f);
      logic [TW-1:0] t;
      t = '0;
      t[(c*NV+v)*FW +: FW] = f;
      return t;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         mval[v] = 2'd0;
         mlvl[v] = 0;
      end
      mimp = '0;
      mcur = 0;
   endtask

   // Applies the decision and the planned clause responses to the model, pushes the
   // expected outcome, then drives the DUT and checks wave count and visibility.
   task automatic decide(input int dv, input bit dval, input int dl);
      exp_t            e;
      logic [NV*FW-1:0] fb_dec;
      logic [TW-1:0]   vec;
      logic [2:0]      f;
      bit              rt, rf, cf, any_new;
      bit              bad [NV];
      bit              rtv [NV];
      bit              rfv [NV];
      int              cyc, k;

      mval[dv] = dval ? 2'd2 : 2'd1;
      mimp[dv] = 1'b0;
      mlvl[dv] = dl;
      mcur     = dl;
      fb_dec   = snap();
      e.kind = 0; e.cvar = 0; cyc = 0;
      for (int w = 0; w < 20; w++) begin
         vec = (w < plan.size()) ? plan[w] : '0;
         cyc = w + 1;
         e.cvar = -1;
         for (int v = 0; v < NV; v++) begin
            rt = 0; rf = 0; cf = 0;
            for (int c = 0; c < NC; c++) begin
               f  = vec[(c*NV+v)*FW +: FW];
               rt = rt | (f[2] & f[1]);
               rf = rf | (f[2] & ~f[1]);
               cf = cf | f[0];
            end
            rtv[v] = rt; rfv[v] = rf;
            bad[v] = cf || (rt && rf) || (rt && mval[v] == 2'd1) || (rf && mval[v] == 2'd2);
            if (bad[v] && e.cvar < 0) e.cvar = v;
         end
         if (e.cvar >= 0) begin
            e.kind = 1;
            break;
         end
         e.cvar = 0;
         any_new = 0;
         for (int v = 0; v < NV; v++) begin
            if (mval[v] == 2'd0 && (rtv[v] || rfv[v])) begin
               mval[v] = rtv[v] ? 2'd2 : 2'd1;
               mimp[v] = 1'b1;
               mlvl[v] = mcur;
               any_new = 1;
            end
         end
         if (!any_new) begin
            e.kind = 0;
            break;
         end
      end
      e.fb = snap();
      sbq.push_back(e);

      @(posedge clk); #1;
      start_i          = 1'b1;
      decision_var_i   = 3'(dv);
      decision_value_i = dval;
      decision_level_i = 5'(dl);
      var_value_tobase_i = '0;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("busy_after_start", 64'(busy_o), 64'd1);
      chk("decision_visible", 64'(var_value_frombase_o), 64'(fb_dec));
      k = 0;
      while (busy_o && k < 20) begin
         var_value_tobase_i = (k < plan.size()) ? plan[k] : '0;
         @(posedge clk); #1;
         k++;
      end
      var_value_tobase_i = '0;
      chk("prop_cycles", 64'(k), 64'(cyc));
      plan.delete();
   endtask

   task automatic backtrack(input int bl, input bit with_start);
      exp_t e;
      for (int v = 0; v < NV; v++) begin
         if (mlvl[v] > bl) begin
            mval[v] = 2'd0;
            mimp[v] = 1'b0;
            mlvl[v] = 0;
         end
      end
      e.kind = 2; e.cvar = 0; e.fb = snap();
      sbq.push_back(e);

      @(posedge clk); #1;
      bkt_i            = 1'b1;
      bkt_level_i      = 5'(bl);
      start_i          = with_start;
      decision_var_i   = 3'($urandom_range(0, NV-1));
      decision_value_i = 1'($urandom_range(0, 1));
      decision_level_i = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      bkt_i   = 1'b0;
      start_i = 1'b0;
      chk("bkt_pulse_high", 64'(apply_backtrack_o), 64'd1);
      @(posedge clk); #1;
      chk("bkt_pulse_one_cycle", 64'(apply_backtrack_o), 64'd0);
      chk("bkt_busy_drop", 64'(busy_o), 64'd0);
   endtask

   task automatic reset_mid_propagate();
      @(posedge clk); #1;
      start_i          = 1'b1;
      decision_var_i   = 3'd0;
      decision_value_i = 1'b1;
      decision_level_i = 5'd4;
      var_value_tobase_i = '0;
      @(posedge clk); #1;
      start_i = 1'b0;
      // A pending implication keeps the DUT in PROPAGATE while reset lands.
      var_value_tobase_i = fld(0, 7, 3'b110);
      rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      var_value_tobase_i = '0;
      chk("rst_mid_fb", 64'(var_value_frombase_o), 64'd0);
      chk("rst_mid_busy", 64'(busy_o), 64'd0);
      chk("rst_mid_done", 64'(done_o), 64'd0);
      chk("rst_mid_conflict", 64'(conflict_o), 64'd0);
      rst = 1'b1;
   endtask

   function automatic logic [TW-1:0] rand_vec();
      logic [TW-1:0] t;
      int r;
      t = '0;
      for (int i = 0; i < NC*NV; i++) begin
         r = $urandom_range(0, 63);
         if (r < 6)        t[i*FW +: FW] = 3'b100;
         else if (r < 12)  t[i*FW +: FW] = 3'b110;
         else if (r == 12) t[i*FW +: FW] = 3'b001;
         else if (r == 13) t[i*FW +: FW] = 3'b010;
      end
      return t;
   endfunction

   // Monitor: pops an expectation whenever a pulse appears, checks the settled state next negedge.
   initial begin : monitor
      exp_t e;
      logic             fb_pending;
      logic [NV*FW-1:0] fb_exp;
      int               kind;
      fb_pending = 1'b0;
      fb_exp     = '0;
      forever begin
         @(negedge clk);
         if (fb_pending) begin
            chk("settled_state", 64'(var_value_frombase_o), 64'(fb_exp));
            fb_pending = 1'b0;
         end
         if (rst && (done_o || conflict_o || apply_backtrack_o)) begin
            kind = conflict_o ? 1 : (done_o ? 0 : 2);
            chk("single_pulse", 64'(done_o + conflict_o + apply_backtrack_o), 64'd1);
            chk("busy_at_pulse", 64'(busy_o), 64'd1);
            if (sbq.size() == 0) begin
               chk("spurious_pulse", 64'(kind), 64'hFF);
            end else begin
               e = sbq.pop_front();
               chk("outcome_kind", 64'(kind), 64'(e.kind));
               if (e.kind == 1 && kind == 1)
                  chk("conflict_var", 64'(conflict_var_o), 64'(e.cvar));
               fb_pending = 1'b1;
               fb_exp     = e.fb;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst = 1'b0;
      start_i = 1'b0; decision_var_i = '0; decision_value_i = 1'b0; decision_level_i = '0;
      bkt_i = 1'b0; bkt_level_i = '0; var_value_tobase_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_fb", 64'(var_value_frombase_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_done", 64'(done_o), 64'd0);
      chk("reset_conflict", 64'(conflict_o), 64'd0);
      chk("reset_bkt", 64'(apply_backtrack_o), 64'd0);
      rst = 1'b1;

      decide(1, 1'b0, 1);
      chk("field1_false", 64'(var_value_frombase_o[1*FW +: FW]), 64'(3'b010));

      plan.push_back(fld(0, 3, 3'b110));
      decide(1, 1'b0, 1);
      chk("field3_implied_true", 64'(var_value_frombase_o[3*FW +: FW]), 64'(3'b101));

      plan.push_back(fld(0, 5, 3'b110) | fld(1, 5, 3'b100));
      decide(2, 1'b1, 2);
      chk("field5_untouched", 64'(var_value_frombase_o[5*FW +: FW]), 64'(3'b000));

      plan.push_back(fld(1, 0, 3'b001));
      decide(6, 1'b0, 3);

      backtrack(0, 1'b0);
      decide(1, 1'b0, 1);
      plan.push_back(fld(0, 3, 3'b110));
      decide(1, 1'b0, 1);
      decide(5, 1'b1, 2);
      backtrack(1, 1'b0);
      chk("bkt_keep1", 64'(var_value_frombase_o[1*FW +: FW]), 64'(3'b010));
      chk("bkt_keep3", 64'(var_value_frombase_o[3*FW +: FW]), 64'(3'b101));
      chk("bkt_free5", 64'(var_value_frombase_o[5*FW +: FW]), 64'(3'b000));

      reset_mid_propagate();
      decide(4, 1'b1, 3);
      backtrack(2, 1'b1);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            backtrack($urandom_range(0, 31), 1'($urandom_range(0, 1)));
         end else begin
            for (int j = 0; j < $urandom_range(0, 3); j++) plan.push_back(rand_vec());
            decide($urandom_range(0, NV-1), 1'($urandom_range(0, 1)), $urandom_range(0, 31));
         end
      end

      repeat (4) @(posedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
